a2d_spi_resp: RTL

SPI responder for the A2D channel protocol: the device end of the link driven by the A2D interface's SPI master. It receives a 16-bit channel-select command per frame and, on the following frame, returns the 12-bit conversion value for the last selected channel. It stands in for the off-chip converter in full-chip simulation and FPGA loopback. Conversion values come from a parent-supplied per-channel table, optionally modified by an internal ramp.

---
 rtl/a2d_pkg.sv | 13 +
 rtl/spi_edge_sync.sv | 21 ++
 rtl/a2d_spi_resp.sv | 128 ++++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared A2D channel-protocol definitions: frame layout, resolution, responder FSM states.
package a2d_pkg;
  typedef enum logic {IDLE, SHIFT} a2d_state_e;

  localparam int A2D_FRM_BITS = 16;
  localparam int A2D_CHNL_MSB = 13;
  localparam int A2D_CHNL_LSB = 11;
  localparam int A2D_RES_W    = 12;
  localparam int A2D_NUM_CHNL = 8;

  // Per-read ramp increment, only referenced when A2D_RESP_RAMP_EN is defined.
  localparam logic [A2D_RES_W-1:0] RAMP_STEP = 12'h010;
endpackage

// File: rtl/spi_edge_sync.sv
// Three-flop synchronizer: two flops for metastability, a third for rise/fall detection.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= {3{RST_VAL}};
    else        sr <= {sr[1:0], din};

  assign sync = sr[1];
  assign rise =  sr[1] & ~sr[2];
  assign fall = ~sr[1] &  sr[2];
endmodule

// File: rtl/a2d_spi_resp.sv
// SPI device end of the A2D link: latches a channel select per frame, returns its value next frame.
// Optional ramp on returned values: define A2D_RESP_RAMP_EN.
module a2d_spi_resp
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [95:0] ch_val,
  output logic        cmd_vld,
  output logic [2:0]  cmd_chnl,
  output logic        frm_err,
  output logic        busy
);
  logic ss_sync, ss_rise, ss_fall;
  logic sclk_rise, sclk_fall, unused_sclk_sync;
  logic [1:0] mosi_sr;
  logic mosi_sync;

  // SS_n and SCLK idle high, so their synchronizers reset high to avoid a false edge.
  spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .din(SS_n),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(SCLK),
    .sync(unused_sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mosi_sr <= '0;
    else        mosi_sr <= {mosi_sr[0], MOSI};

  assign mosi_sync = mosi_sr[1];

  a2d_state_e state, state_nxt;
  logic [A2D_FRM_BITS-1:0] tx_shft, rx_shft;
  logic [4:0] bit_cnt;
  logic ld, rx_sh, tx_sh, fin_ok, fin_err;

  logic [A2D_NUM_CHNL-1:0][A2D_RES_W-1:0] ch_tbl;
  logic [A2D_RES_W-1:0] rd_val;

  assign ch_tbl = ch_val;

`ifdef A2D_RESP_RAMP_EN
  logic [A2D_NUM_CHNL-1:0][A2D_RES_W-1:0] ofs;

  assign rd_val = ch_tbl[cmd_chnl] + ofs[cmd_chnl];

  // cmd_chnl still holds the channel read this frame on the closing clk.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      ofs <= '0;
    else if (fin_ok) ofs[cmd_chnl] <= ofs[cmd_chnl] + RAMP_STEP;
`else
  assign rd_val = ch_tbl[cmd_chnl];
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // SS_n rise takes priority over any SCLK edge seen on the same clk.
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    rx_sh     = 1'b0;
    tx_sh     = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    case (state)
      IDLE: if (ss_fall) begin
        state_nxt = SHIFT;
        ld        = 1'b1;
      end
      SHIFT: begin
        if (ss_rise) begin
          state_nxt = IDLE;
          if (bit_cnt == 5'(A2D_FRM_BITS)) fin_ok  = 1'b1;
          else                             fin_err = 1'b1;
        end else if (sclk_rise) begin
          rx_sh = 1'b1;
        end else if (sclk_fall && bit_cnt != 5'd0) begin
          tx_sh = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_shft <= '0;
      rx_shft <= '0;
      bit_cnt <= '0;
    end else if (ld) begin
      tx_shft <= {4'h0, rd_val};
      rx_shft <= '0;
      bit_cnt <= '0;
    end else begin
      if (rx_sh) begin
        rx_shft <= {rx_shft[A2D_FRM_BITS-2:0], mosi_sync};
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end
      if (tx_sh) tx_shft <= {tx_shft[A2D_FRM_BITS-2:0], 1'b0};
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_chnl <= '0;
      cmd_vld  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      cmd_vld <= fin_ok;
      frm_err <= fin_err;
      if (fin_ok) cmd_chnl <= rx_shft[A2D_CHNL_MSB:A2D_CHNL_LSB];
    end

  logic [12:0] unused_rx;
  assign unused_rx = {rx_shft[15:14], rx_shft[10:0]};

  assign busy = (state == SHIFT);
  assign MISO = ~ss_sync & tx_shft[A2D_FRM_BITS-1];
endmodule
